// File: rtl/mem_access_sequencer_pkg.sv
// rtl/mem_access_sequencer_pkg.sv - shared types, beat limit and size decode for the memory access sequencer
// Contents: access_size_t, state_t, MAX_BEATS, beats_for_size().
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int MAX_BEATS = 4;

    // Size code 3 is not a legal encoding and is handled as a word.
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - request, response and byte-memory signals of the access sequencer
// Modports: slave = sequencer view; master = load/store stage plus memory array view.
interface mem_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_sequencer_load_extend.sv
// rtl/mem_access_sequencer_load_extend.sv - size and sign extension of the assembled load word
// Ports: asm_data (assembled bytes), size, is_unsigned in; ext_data out.
module mem_load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] asm_data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = asm_data;
        case (size)
            SZ_BYTE: ext_data = {{24{asm_data[7] & ~is_unsigned}}, asm_data[7:0]};
            SZ_HALF: ext_data = {{16{asm_data[15] & ~is_unsigned}}, asm_data[15:0]};
            default: ext_data = asm_data;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - splits byte/half/word loads and stores into single-byte memory beats
// Ports: clk, rst_n; bus (mem_access_sequencer_if.slave): req_*, rsp_*, mem_*.
// Optional: MEM_ACCESS_STATS_EN adds stat_rd_beats / stat_wr_beats saturating beat counters.
module mem_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_access_sequencer_if.slave  bus
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]            stat_rd_beats,
    output logic [31:0]            stat_wr_beats
`endif
);

    localparam int BEAT_W = $clog2(MAX_BEATS);

    state_t              state, next_state;
    logic [BEAT_W-1:0]   beat;
    logic [2:0]          n_beats;
    logic                lat_write;
    logic [1:0]          lat_size;
    logic                lat_unsigned;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;
    logic [31:0]         asm_data;
    logic [31:0]         ext_data;
    logic                last_beat;
    logic [31:0]         beat_offset;

    assign last_beat   = (3'(beat) + 3'd1) == n_beats;
    assign beat_offset = 32'(beat) * 32'(ADDR_STRIDE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory outputs are decoded from registered state so that reset
    // removes mem_we without waiting for a clock edge.
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'd0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 8'd0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_we   = lat_write;
                bus.mem_addr = lat_addr + beat_offset;
                if (lat_write) begin
                    bus.mem_wdata = lat_wdata[{beat, 3'b000} +: 8];
                end
                if (last_beat) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = lat_write ? 32'd0 : ext_data;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat         <= '0;
            n_beats      <= 3'd0;
            lat_write    <= 1'b0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            asm_data     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write    <= bus.req_write;
                        lat_size     <= bus.req_size;
                        lat_unsigned <= bus.req_unsigned;
                        lat_addr     <= bus.req_addr;
                        lat_wdata    <= bus.req_wdata;
                        n_beats      <= beats_for_size(bus.req_size);
                        beat         <= '0;
                        asm_data     <= 32'd0;
                    end
                end
                ACCESS: begin
                    if (!lat_write) begin
                        asm_data[{beat, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    // Four beats wrap the counter back to 0, which is harmless
                    // because the FSM leaves ACCESS on the same edge.
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    mem_load_extend u_load_extend (
        .asm_data    (asm_data),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .ext_data    (ext_data)
    );

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_beats <= 32'd0;
            stat_wr_beats <= 32'd0;
        end else if (state == ACCESS) begin
            if (lat_write) begin
                if (stat_wr_beats != 32'hFFFF_FFFF) begin
                    stat_wr_beats <= stat_wr_beats + 32'd1;
                end
            end else begin
                if (stat_rd_beats != 32'hFFFF_FFFF) begin
                    stat_rd_beats <= stat_rd_beats + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed and randomized bench for mem_access_sequencer against a byte-array model
module tb_mem_access_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_sequencer_if bus ();

`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] stat_rd_beats, stat_wr_beats;
`endif

    mem_access_sequencer #(.ADDR_STRIDE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_rd_beats (stat_rd_beats),
        .stat_wr_beats (stat_wr_beats)
`endif
    );

    // Environment memory array: combinational read, write on the clock edge.
    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;
    longint exp_rd_beats = 0;
    longint exp_wr_beats = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extend_ref(input logic [31:0] raw, input logic [1:0] size, input bit uns);
        logic [31:0] b, h;
        b = raw & 32'hFF;
        h = raw & 32'hFFFF;
        if (size == 2'd0) return (!uns && b >= 32'd128) ? b - 32'd256 : b;
        if (size == 2'd1) return (!uns && h >= 32'd32768) ? h - 32'd65536 : h;
        return raw;
    endfunction

    // Called at a negedge with the sequencer idle; returns at a negedge with it idle again.
    task automatic do_req(input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int bp);
        int n;
        logic [31:0] a, raw, exp;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        raw = 32'd0;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(4 * k);
            check("req_ready_access", 32'(bus.req_ready), 32'd0);
            check("rsp_valid_access", 32'(bus.rsp_valid), 32'd0);
            check("mem_we_access", 32'(bus.mem_we), 32'(wr));
            check("mem_addr", bus.mem_addr, a);
            if (wr) begin
                check("mem_wdata", 32'(bus.mem_wdata), 32'(wdata[8*k +: 8]));
                ref_mem[a[11:2]] = wdata[8*k +: 8];
                exp_wr_beats++;
            end else begin
                raw = raw | (32'(ref_mem[a[11:2]]) << (8 * k));
                exp_rd_beats++;
            end
            @(negedge clk);
        end
        exp = wr ? 32'd0 : extend_ref(raw, size, uns);
        for (int i = 0; i <= bp; i++) begin
            bus.rsp_ready = (i == bp);
            bus.req_valid = (i == bp) ? 1'b0 : 1'($urandom);
            check("rsp_valid_resp", 32'(bus.rsp_valid), 32'd1);
            check("rsp_rdata", bus.rsp_rdata, exp);
            check("req_ready_resp", 32'(bus.req_ready), 32'd0);
            check("mem_we_resp", 32'(bus.mem_we), 32'd0);
            check("mem_addr_resp", bus.mem_addr, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.rsp_ready    = 1'b0;

        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_010C, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_010C, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0108, 32'h0, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0200, 32'h0000_007F, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 3);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);

        // Abort a word store after two beats have been committed.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h0000_0300;
        bus.req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_mem_addr", bus.mem_addr, 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        ref_mem[32'h300 >> 2] = 8'hDD;
        ref_mem[32'h304 >> 2] = 8'hCC;
        exp_wr_beats = 0;
        exp_rd_beats = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_byte0", 32'(mem[32'h300 >> 2]), 32'h0000_00DD);
        check("abort_byte1", 32'(mem[32'h304 >> 2]), 32'h0000_00CC);
        check("abort_byte2", 32'(mem[32'h308 >> 2]), 32'h0000_0000);
        check("abort_byte3", 32'(mem[32'h30C >> 2]), 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        end

        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom, $urandom, $urandom_range(0, 3));
        end

`ifdef MEM_ACCESS_STATS_EN
        check("stat_rd_beats", stat_rd_beats, 32'(exp_rd_beats));
        check("stat_wr_beats", stat_wr_beats, 32'(exp_wr_beats));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
